crlb_peak_select: RTL

- Multi-channel correlation peak selector placed after the OQPSK demodulator's per-channel correlator outputs.
- Accumulates the magnitude of each channel's signed correlation value over a window of strobed samples, then serially scans for the strongest channel.
- Reports the winning channel and its energy, and runs a lock/unlock hysteresis FSM so downstream timing or phase selection uses a stable channel choice.
- Generalises the fixed 4-channel correlation tap-off to NCH channels with configurable width, window length and hysteresis.

---
 rtl/crlb_peak_select.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/crlb_peak_select.sv
// Multi-channel correlation peak selector: windowed magnitude accumulation,
// serial max scan and lock/unlock hysteresis on the winning channel.
module crlb_peak_select #(
    parameter int NCH        = 4,
    parameter int W          = 29,
    parameter int ACC_LEN    = 8,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 2,
    parameter int CW         = $clog2(NCH),
    parameter int AW         = W + $clog2(ACC_LEN)
) (
    input  logic             C,
    input  logic             Reset_l,
    input  logic             En,
    input  logic [NCH*W-1:0] crlb,
    output logic [CW-1:0]    best_ch,
    output logic [AW-1:0]    best_mag,
    output logic             win_valid,
    output logic             lock,
    output logic [CW-1:0]    lock_ch
);
    localparam int CNTW = $clog2(ACC_LEN);
    localparam int AGW  = $clog2(LOCK_CNT + 1);
    localparam int MSW  = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE} state_t;

    state_t            r_state;
    logic [CNTW-1:0]   r_cnt;
    logic [CW-1:0]     r_idx;
    logic [CW-1:0]     r_arg;
    logic [AW-1:0]     r_max;
    logic [CW-1:0]     r_best_ch;
    logic [AW-1:0]     r_best_mag;
    logic              r_win_valid;
    logic              r_lock;
    logic [CW-1:0]     r_lock_ch;
    logic [CW-1:0]     r_prev;
    logic [AGW-1:0]    r_agree;
    logic [MSW-1:0]    r_miss;

    logic              w_close;
    logic [AW-1:0]     w_snap [NCH];
    logic [AGW-1:0]    w_agree_upd;
    logic [MSW-1:0]    w_miss_upd;

    assign w_close = En && (r_cnt == CNTW'(ACC_LEN - 1));

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [W-1:0]  w_raw;
            logic [W-1:0]  w_mag;
            logic [AW-1:0] w_sum;
            logic [AW-1:0] r_acc;
            logic [AW-1:0] r_snap;

            // W-bit unsigned negate maps the most negative input to 2^(W-1) exactly
            assign w_raw = crlb[gi*W +: W];
            assign w_mag = w_raw[W-1] ? (~w_raw + W'(1)) : w_raw;
            assign w_sum = r_acc + AW'(w_mag);
            assign w_snap[gi] = r_snap;

            always_ff @(posedge C) begin
                if (!Reset_l) begin
                    r_acc  <= '0;
                    r_snap <= '0;
                end else if (En) begin
                    if (w_close) begin
                        r_snap <= w_sum;
                        r_acc  <= '0;
                    end else begin
                        r_acc <= w_sum;
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        w_agree_upd = AGW'(1);
        if ((r_arg == r_prev) && (r_agree != '0)) begin
            w_agree_upd = (r_agree >= AGW'(LOCK_CNT)) ? AGW'(LOCK_CNT) : r_agree + AGW'(1);
        end
        w_miss_upd = r_miss + MSW'(1);
    end

    always_ff @(posedge C) begin
        if (!Reset_l) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_arg       <= '0;
            r_max       <= '0;
            r_best_ch   <= '0;
            r_best_mag  <= '0;
            r_win_valid <= 1'b0;
            r_lock      <= 1'b0;
            r_lock_ch   <= '0;
            r_prev      <= '0;
            r_agree     <= '0;
            r_miss      <= '0;
        end else begin
            r_win_valid <= 1'b0;
            if (En) begin
                r_cnt <= w_close ? '0 : r_cnt + CNTW'(1);
            end

            case (r_state)
                S_SCAN: begin
                    // strict compare keeps ties on the lowest index
                    if ((r_idx == '0) || (w_snap[r_idx] > r_max)) begin
                        r_max <= w_snap[r_idx];
                        r_arg <= r_idx;
                    end
                    if (r_idx == CW'(NCH - 1)) begin
                        r_state <= S_DECIDE;
                    end else begin
                        r_idx <= r_idx + CW'(1);
                    end
                end
                S_DECIDE: begin
                    r_best_ch   <= r_arg;
                    r_best_mag  <= r_max;
                    r_win_valid <= 1'b1;
                    r_prev      <= r_arg;
                    r_state     <= S_IDLE;
                    if (!r_lock) begin
                        r_agree <= w_agree_upd;
                        if (w_agree_upd == AGW'(LOCK_CNT)) begin
                            r_lock    <= 1'b1;
                            r_lock_ch <= r_arg;
                            r_miss    <= '0;
                        end
                    end else if (r_arg == r_lock_ch) begin
                        r_miss <= '0;
                    end else if (w_miss_upd == MSW'(UNLOCK_CNT)) begin
                        // dropping lock makes this winner the new candidate
                        r_lock  <= 1'b0;
                        r_miss  <= '0;
                        r_agree <= AGW'(1);
                    end else begin
                        r_miss <= w_miss_upd;
                    end
                end
                default: ;
            endcase

            if (w_close) begin
                r_state <= S_SCAN;
                r_idx   <= '0;
            end
        end
    end

    assign best_ch   = r_best_ch;
    assign best_mag  = r_best_mag;
    assign win_valid = r_win_valid;
    assign lock      = r_lock;
    assign lock_ch   = r_lock_ch;

endmodule
